integrator_gain_sched: RTL and testbench
========================================

# integrator_gain_sched

Sequencer for the gyro loop integrator (integrator_vth_v2). Zeroes the integrator and enables it at a coarse gain selection, then steps `o_gain_sel` one code at a time toward a fine final selection, dwelling until the loop error stays in band. On persistent saturation it re-zeroes and retries, and after a bounded number of retries it declares a fault. Sits between the host register file and the integrator's `i_gain_sel` / `i_en` / `i_zero` inputs.

## Interface
Parameters:
- `ZERO_CYC`, 4: cycles `o_zero` is held high per zeroing pass (≥1).
- `SAT_CYC`, 16: consecutive saturated cycles that trigger a saturation event (≥1).
- `MAX_RETRY`, 3: saturation events tolerated before FAULT (1..15).

Ports:
- `i_clk` in 1: single clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_start` in 1: start pulse; acted on in IDLE and FAULT only.
- `i_abort` in 1: return to IDLE from any state.
- `i_gain_sel_init` in 6: coarse selection; latched on accepted start.
- `i_gain_sel_final` in 6: final selection; latched on accepted start.
- `i_dwell` in 16: consecutive in-band cycles required per step; 0 is treated as 1; latched on start.
- `i_lock_th` in 32: unsigned error band; latched on start.
- `i_err` in 32: signed loop error, same value fed to the integrator.
- `i_sat_flag_p` / `i_sat_flag_n` in 1: integrator saturation flags.
- `o_gain_sel` out 6: to integrator `i_gain_sel`.
- `o_en` out 1: to integrator `i_en`.
- `o_zero` out 1: to integrator `i_zero`.
- `o_locked` out 1: final gain reached and settled.
- `o_fault` out 1: sticky fault.
- `o_busy` out 1: any state except IDLE/FAULT.
- `o_state` out 3: current state code.
- `o_retry` out 4: saturation events in the current run.

## Operation
- States: IDLE=0, ZERO=1, RUN=2, STEP=3, LOCK=4, FAULT=5.
- IDLE: `o_en`=0, `o_zero`=0. On `i_start`: latch configuration, set `o_gain_sel`=init, clear `o_retry`, go to ZERO.
- ZERO: `o_zero`=1, `o_en`=0 for exactly `ZERO_CYC` cycles, then RUN.
- RUN: `o_en`=1. Compute `|i_err|`; the value -2^31 saturates to 0x7FFF_FFFF. In-band means `|i_err|` ≤ `lock_th`. The dwell counter increments on in-band cycles and clears to 0 on out-of-band cycles. When the count reaches the latched dwell value: go to LOCK if `o_gain_sel`==final, otherwise go to STEP.
- STEP: one cycle. `o_gain_sel` moves one code toward final (+1 or -1). Dwell counter clears. Return to RUN.
- LOCK: `o_locked`=1, `o_en`=1, `o_gain_sel` held. The state persists. Error excursions alone do not leave LOCK.
- Saturation counter: counts consecutive cycles with `sat_p|sat_n` in RUN/STEP/LOCK; clears otherwise. Reaching `SAT_CYC` is a saturation event:
  - if `o_retry`==`MAX_RETRY`: go to FAULT;
  - else: increment `o_retry`, set `o_gain_sel`=init, clear `o_locked`, go to ZERO.
- FAULT: `o_en`=0, `o_zero`=0, `o_fault`=1. `o_gain_sel` and `o_retry` are held. `i_start` clears `o_fault` and restarts exactly as from IDLE.
- Priority, highest first: `i_abort` > saturation event > dwell completion.
- `i_abort`: go to IDLE next cycle, clear `o_locked`/`o_fault`, clear counters. `o_gain_sel` is held.
- `i_start` is ignored in ZERO/RUN/STEP/LOCK.
- init==final: the first dwell completion goes straight to LOCK with no STEP.

## Timing
- Reset values: `o_state`=IDLE, `o_gain_sel`=0, `o_retry`=0, all 1-bit outputs 0, all counters 0.
- All outputs are registered and reflect the state entered at the clock edge after the causing condition.
- `i_start` sampled at edge N:
  - `o_zero`=1 for edges N+1 .. N+ZERO_CYC;
  - `o_en`=1 from edge N+ZERO_CYC+1.
- With constant in-band error and dwell D, each gain step costs D+1 cycles (D in RUN, 1 in STEP).
- `o_gain_sel` changes at the STEP entry edge.
- `o_locked` rises at the LOCK entry edge.
- A saturation event is taken on the edge after the `SAT_CYC`-th consecutive flagged cycle is sampled.
- Asserting reset mid-run forces all outputs to their reset values immediately. There is no stored state across reset.

## Structure
- Shared package `integrator_gain_sched_pkg` holds:
  - state encoding constants;
  - widths (GAIN_W=6, ERR_W=32, DWELL_W=16, RETRY_W=4).
- Sub-module `err_band_cmp` is a registered-free combinational abs-and-compare (saturating abs, unsigned ≤). It is reused by other loop monitors.
- The FSM, counters and output registers live in the top.

## Test plan
- Reset and idle: hold `i_rst_n`=0 then release, no start → all outputs 0 and `o_state`=0 indefinitely.
- Nominal step-up: init=0, final=3, dwell=5, th=100, `i_err`=10, start at N:
  - `o_zero` high N+1..N+4, `o_en` high from N+5;
  - `o_gain_sel` steps 1, 2, 3 at 6-cycle intervals;
  - `o_locked` rises 6 cycles after the last step.
- Step-down and dwell reset:
  - init=5, final=2, with `i_err`=200 for 3 cycles mid-dwell → dwell counter restarts;
  - `o_gain_sel` goes 4, 3, 2, then LOCK.
- Saturation retry: force `sat_p`=1 for 16 cycles in RUN → `o_retry`=1, `o_gain_sel`=init, ZERO pass of 4 cycles, RUN resumes.
- Fault: saturation repeated 4 times with MAX_RETRY=3 → FAULT, `o_fault`=1, `o_en`=0. Then `i_start` → `o_fault`=0, `o_retry`=0, ZERO.
- Priority and abort:
  - `i_abort` in the same cycle as the 16th saturated cycle → IDLE, `o_retry` unchanged;
  - `i_start` during RUN ignored;
  - `i_err`=0x8000_0000 with th=0x7FFF_FFFE counts as out-of-band.

Source files
------------

// File: rtl/integrator_gain_sched_pkg.sv
// Shared types and widths for the integrator gain sequencer and its loop monitors.
// The state codes are visible to the host through o_state.
package integrator_gain_sched_pkg;

   localparam int GAIN_W  = 6;
   localparam int ERR_W   = 32;
   localparam int DWELL_W = 16;
   localparam int RETRY_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ZERO  = 3'd1,
      ST_RUN   = 3'd2,
      ST_STEP  = 3'd3,
      ST_LOCK  = 3'd4,
      ST_FAULT = 3'd5
   } state_t;

   // The most negative value has no positive twin, so it clamps to the largest positive one
   function automatic logic [ERR_W-1:0] sat_abs(input logic [ERR_W-1:0] v);
      if (v == {1'b1, {(ERR_W-1){1'b0}}})
         return {1'b0, {(ERR_W-1){1'b1}}};
      else if (v[ERR_W-1])
         return ~v + 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/err_band_cmp.sv
// Combinational check that a signed loop error lies inside an unsigned band.
// It holds no state, so any loop monitor can reuse it.
module err_band_cmp
   import integrator_gain_sched_pkg::*;
(
   input  logic [ERR_W-1:0] err,
   input  logic [ERR_W-1:0] lock_th,
   output logic             in_band
);

   logic [ERR_W-1:0] err_mag;

   assign err_mag = sat_abs(err);
   assign in_band = (err_mag <= lock_th);

endmodule

// File: rtl/integrator_gain_sched.sv
// Gain sequencer for the gyro loop integrator: zero, run, step the gain toward its final
// code, then lock. Persistent saturation triggers a bounded number of retries before a fault.
module integrator_gain_sched
   import integrator_gain_sched_pkg::*;
#(
   parameter int ZERO_CYC  = 4,
   parameter int SAT_CYC   = 16,
   parameter int MAX_RETRY = 3
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [GAIN_W-1:0]  i_gain_sel_init,
   input  logic [GAIN_W-1:0]  i_gain_sel_final,
   input  logic [DWELL_W-1:0] i_dwell,
   input  logic [ERR_W-1:0]   i_lock_th,
   input  logic [ERR_W-1:0]   i_err,
   input  logic               i_sat_flag_p,
   input  logic               i_sat_flag_n,
   output logic [GAIN_W-1:0]  o_gain_sel,
   output logic               o_en,
   output logic               o_zero,
   output logic               o_locked,
   output logic               o_fault,
   output logic               o_busy,
   output logic [2:0]         o_state,
   output logic [RETRY_W-1:0] o_retry
);

   localparam int ZC_W = (ZERO_CYC > 1) ? $clog2(ZERO_CYC) : 1;
   localparam int SC_W = (SAT_CYC > 1) ? $clog2(SAT_CYC) : 1;

   state_t              state_q, state_d;
   logic [GAIN_W-1:0]   gain_q, gain_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic [ZC_W-1:0]     zero_cnt_q, zero_cnt_d;
   logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
   logic [SC_W-1:0]     sat_cnt_q, sat_cnt_d;
   logic [GAIN_W-1:0]   init_q, final_q;
   logic [DWELL_W-1:0]  dwell_q;
   logic [ERR_W-1:0]    th_q;
   logic                load_cfg;
   logic                in_band;
   logic                active;
   logic                sat_any;
   logic                sat_event;
   logic                dwell_done;
   logic                en_q, zero_q, locked_q, fault_q, busy_q;

   err_band_cmp u_band (
      .err     (i_err),
      .lock_th (th_q),
      .in_band (in_band)
   );

   assign active     = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_LOCK);
   assign sat_any    = i_sat_flag_p | i_sat_flag_n;
   assign sat_event  = active && sat_any && (sat_cnt_q == SC_W'(SAT_CYC - 1));
   assign dwell_done = in_band && (dwell_cnt_q == dwell_q - 1'b1);

   // Next-state decode; abort outranks a saturation event, which outranks dwell completion
   always_comb begin
      state_d     = state_q;
      gain_d      = gain_q;
      retry_d     = retry_q;
      zero_cnt_d  = zero_cnt_q;
      dwell_cnt_d = dwell_cnt_q;
      sat_cnt_d   = '0;
      load_cfg    = 1'b0;

      if (active && sat_any)
         sat_cnt_d = sat_cnt_q + 1'b1;

      if (i_abort) begin
         state_d     = ST_IDLE;
         zero_cnt_d  = '0;
         dwell_cnt_d = '0;
         sat_cnt_d   = '0;
      end else if (sat_event) begin
         zero_cnt_d  = '0;
         dwell_cnt_d = '0;
         sat_cnt_d   = '0;
         if (retry_q == RETRY_W'(MAX_RETRY)) begin
            state_d = ST_FAULT;
         end else begin
            state_d = ST_ZERO;
            retry_d = retry_q + 1'b1;
            gain_d  = init_q;
         end
      end else begin
         case (state_q)
            ST_IDLE, ST_FAULT: begin
               if (i_start) begin
                  state_d     = ST_ZERO;
                  load_cfg    = 1'b1;
                  gain_d      = i_gain_sel_init;
                  retry_d     = '0;
                  zero_cnt_d  = '0;
                  dwell_cnt_d = '0;
               end
            end
            ST_ZERO: begin
               dwell_cnt_d = '0;
               if (zero_cnt_q == ZC_W'(ZERO_CYC - 1)) begin
                  state_d    = ST_RUN;
                  zero_cnt_d = '0;
               end else begin
                  zero_cnt_d = zero_cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (dwell_done) begin
                  dwell_cnt_d = '0;
                  if (gain_q == final_q) begin
                     state_d = ST_LOCK;
                  end else begin
                     state_d = ST_STEP;
                     gain_d  = (gain_q < final_q) ? gain_q + 1'b1 : gain_q - 1'b1;
                  end
               end else if (in_band) begin
                  dwell_cnt_d = dwell_cnt_q + 1'b1;
               end else begin
                  dwell_cnt_d = '0;
               end
            end
            ST_STEP: begin
               dwell_cnt_d = '0;
               state_d     = ST_RUN;
            end
            ST_LOCK: begin
               dwell_cnt_d = '0;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         gain_q      <= '0;
         retry_q     <= '0;
         zero_cnt_q  <= '0;
         dwell_cnt_q <= '0;
         sat_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         gain_q      <= gain_d;
         retry_q     <= retry_d;
         zero_cnt_q  <= zero_cnt_d;
         dwell_cnt_q <= dwell_cnt_d;
         sat_cnt_q   <= sat_cnt_d;
      end
   end

   // A zero dwell would never complete, so it is stored as one
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         init_q  <= '0;
         final_q <= '0;
         dwell_q <= DWELL_W'(1);
         th_q    <= '0;
      end else if (load_cfg) begin
         init_q  <= i_gain_sel_init;
         final_q <= i_gain_sel_final;
         dwell_q <= (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
         th_q    <= i_lock_th;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         en_q     <= 1'b0;
         zero_q   <= 1'b0;
         locked_q <= 1'b0;
         fault_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         en_q     <= (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_LOCK);
         zero_q   <= (state_d == ST_ZERO);
         locked_q <= (state_d == ST_LOCK);
         fault_q  <= (state_d == ST_FAULT);
         busy_q   <= (state_d != ST_IDLE) && (state_d != ST_FAULT);
      end
   end

   assign o_gain_sel = gain_q;
   assign o_en       = en_q;
   assign o_zero     = zero_q;
   assign o_locked   = locked_q;
   assign o_fault    = fault_q;
   assign o_busy     = busy_q;
   assign o_state    = state_q;
   assign o_retry    = retry_q;

endmodule

// File: tb/tb_integrator_gain_sched.sv
// Directed bench for integrator_gain_sched: a table of cycle-count vectors for the
// stepping paths plus hand-written saturation, fault, abort and reset sequences.
module tb_integrator_gain_sched;
   import integrator_gain_sched_pkg::*;

   typedef struct packed {
      logic [2:0] st;
      logic [5:0] gain;
      logic       en;
      logic       zero;
      logic       locked;
      logic       fault;
      logic       busy;
      logic [3:0] retry;
   } obs_t;

   typedef struct {
      int          ncyc;
      logic        start;
      logic        abort;
      logic [5:0]  init;
      logic [5:0]  fin;
      logic [15:0] dwell;
      logic [31:0] th;
      logic [31:0] err;
      obs_t        exp;
   } vec_t;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_start;
   logic        i_abort;
   logic [5:0]  i_gain_sel_init;
   logic [5:0]  i_gain_sel_final;
   logic [15:0] i_dwell;
   logic [31:0] i_lock_th;
   logic [31:0] i_err;
   logic        i_sat_flag_p;
   logic        i_sat_flag_n;
   logic [5:0]  o_gain_sel;
   logic        o_en;
   logic        o_zero;
   logic        o_locked;
   logic        o_fault;
   logic        o_busy;
   logic [2:0]  o_state;
   logic [3:0]  o_retry;

   int          n_vec;
   int          n_miss;
   vec_t        vecs[$];
   logic [5:0]  cfg_init;
   logic [5:0]  cfg_fin;
   logic [15:0] cfg_dwell;
   logic [31:0] cfg_th;

   integrator_gain_sched #(.ZERO_CYC(4), .SAT_CYC(16), .MAX_RETRY(3)) dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_start          (i_start),
      .i_abort          (i_abort),
      .i_gain_sel_init  (i_gain_sel_init),
      .i_gain_sel_final (i_gain_sel_final),
      .i_dwell          (i_dwell),
      .i_lock_th        (i_lock_th),
      .i_err            (i_err),
      .i_sat_flag_p     (i_sat_flag_p),
      .i_sat_flag_n     (i_sat_flag_n),
      .o_gain_sel       (o_gain_sel),
      .o_en             (o_en),
      .o_zero           (o_zero),
      .o_locked         (o_locked),
      .o_fault          (o_fault),
      .o_busy           (o_busy),
      .o_state          (o_state),
      .o_retry          (o_retry)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   function automatic obs_t mk_obs(logic [2:0] st, logic [5:0] gain, logic en, logic zero,
                                   logic locked, logic fault, logic busy, logic [3:0] retry);
      obs_t o;
      o.st = st; o.gain = gain; o.en = en; o.zero = zero;
      o.locked = locked; o.fault = fault; o.busy = busy; o.retry = retry;
      return o;
   endfunction

   function automatic void add_vec(int n, logic st, logic ab, logic [31:0] err, obs_t e);
      vec_t v;
      v.ncyc = n; v.start = st; v.abort = ab; v.err = err; v.exp = e;
      v.init = cfg_init; v.fin = cfg_fin; v.dwell = cfg_dwell; v.th = cfg_th;
      vecs.push_back(v);
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input obs_t exp);
      obs_t act;
      act = {o_state, o_gain_sel, o_en, o_zero, o_locked, o_fault, o_busy, o_retry};
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got st=%0d gain=%0d en=%b zero=%b lock=%b fault=%b busy=%b retry=%0d, want st=%0d gain=%0d en=%b zero=%b lock=%b fault=%b busy=%b retry=%0d",
                  name, act.st, act.gain, act.en, act.zero, act.locked, act.fault, act.busy, act.retry,
                  exp.st, exp.gain, exp.en, exp.zero, exp.locked, exp.fault, exp.busy, exp.retry);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      i_start          = v.start;
      i_abort          = v.abort;
      i_err            = v.err;
      i_gain_sel_init  = v.init;
      i_gain_sel_final = v.fin;
      i_dwell          = v.dwell;
      i_lock_th        = v.th;
      repeat (v.ncyc) tick();
   endtask

   task automatic run_cyc(input int n, input logic sp, input logic sn, input logic ab);
      i_sat_flag_p = sp;
      i_sat_flag_n = sn;
      i_abort      = ab;
      repeat (n) tick();
      i_sat_flag_p = 1'b0;
      i_sat_flag_n = 1'b0;
      i_abort      = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_miss = 0;
      i_rst_n = 1'b0;
      i_start = 1'b1;
      i_abort = 1'b0;
      i_gain_sel_init = 6'd9;
      i_gain_sel_final = 6'd12;
      i_dwell = 16'd2;
      i_lock_th = 32'd50;
      i_err = 32'd0;
      i_sat_flag_p = 1'b1;
      i_sat_flag_n = 1'b0;

      // Reset holds everything at zero even with start and saturation driven
      repeat (3) tick();
      checkOutput("in_reset", mk_obs(ST_IDLE, 0, 0, 0, 0, 0, 0, 0));
      i_start = 1'b0;
      i_sat_flag_p = 1'b0;
      i_rst_n = 1'b1;
      repeat (5) tick();
      checkOutput("idle_after_reset", mk_obs(ST_IDLE, 0, 0, 0, 0, 0, 0, 0));

      // Nominal step-up 0 -> 3, dwell 5
      cfg_init = 6'd0; cfg_fin = 6'd3; cfg_dwell = 16'd5; cfg_th = 32'd100;
      add_vec(1, 1, 0, 32'd10,   mk_obs(ST_ZERO, 0, 0, 1, 0, 0, 1, 0));
      add_vec(3, 0, 0, 32'd10,   mk_obs(ST_ZERO, 0, 0, 1, 0, 0, 1, 0));
      add_vec(1, 0, 0, 32'd10,   mk_obs(ST_RUN,  0, 1, 0, 0, 0, 1, 0));
      add_vec(4, 0, 0, 32'd10,   mk_obs(ST_RUN,  0, 1, 0, 0, 0, 1, 0));
      add_vec(1, 0, 0, 32'd10,   mk_obs(ST_STEP, 1, 1, 0, 0, 0, 1, 0));
      add_vec(1, 0, 0, 32'd10,   mk_obs(ST_RUN,  1, 1, 0, 0, 0, 1, 0));
      add_vec(5, 0, 0, 32'd10,   mk_obs(ST_STEP, 2, 1, 0, 0, 0, 1, 0));
      add_vec(6, 0, 0, 32'd10,   mk_obs(ST_STEP, 3, 1, 0, 0, 0, 1, 0));
      add_vec(5, 0, 0, 32'd10,   mk_obs(ST_RUN,  3, 1, 0, 0, 0, 1, 0));
      add_vec(1, 0, 0, 32'd10,   mk_obs(ST_LOCK, 3, 1, 0, 1, 0, 1, 0));
      add_vec(3, 0, 0, 32'd5000, mk_obs(ST_LOCK, 3, 1, 0, 1, 0, 1, 0));
      add_vec(2, 1, 0, 32'd10,   mk_obs(ST_LOCK, 3, 1, 0, 1, 0, 1, 0));
      add_vec(1, 0, 1, 32'd10,   mk_obs(ST_IDLE, 3, 0, 0, 0, 0, 0, 0));

      // Step-down 5 -> 2, dwell 4, with an out-of-band burst restarting the dwell count
      cfg_init = 6'd5; cfg_fin = 6'd2; cfg_dwell = 16'd4; cfg_th = 32'd100;
      add_vec(1, 1, 0, 32'd10,  mk_obs(ST_ZERO, 5, 0, 1, 0, 0, 1, 0));
      add_vec(4, 0, 0, 32'd10,  mk_obs(ST_RUN,  5, 1, 0, 0, 0, 1, 0));
      add_vec(2, 0, 0, 32'd10,  mk_obs(ST_RUN,  5, 1, 0, 0, 0, 1, 0));
      add_vec(3, 0, 0, 32'd200, mk_obs(ST_RUN,  5, 1, 0, 0, 0, 1, 0));
      add_vec(3, 0, 0, 32'd10,  mk_obs(ST_RUN,  5, 1, 0, 0, 0, 1, 0));
      add_vec(1, 0, 0, 32'd10,  mk_obs(ST_STEP, 4, 1, 0, 0, 0, 1, 0));
      add_vec(1, 0, 0, 32'd10,  mk_obs(ST_RUN,  4, 1, 0, 0, 0, 1, 0));
      add_vec(4, 0, 0, 32'd10,  mk_obs(ST_STEP, 3, 1, 0, 0, 0, 1, 0));
      add_vec(5, 0, 0, 32'd10,  mk_obs(ST_STEP, 2, 1, 0, 0, 0, 1, 0));
      add_vec(4, 0, 0, 32'd10,  mk_obs(ST_RUN,  2, 1, 0, 0, 0, 1, 0));
      add_vec(1, 0, 0, 32'd10,  mk_obs(ST_LOCK, 2, 1, 0, 1, 0, 1, 0));
      add_vec(1, 0, 1, 32'd10,  mk_obs(ST_IDLE, 2, 0, 0, 0, 0, 0, 0));

      // Band edges with init==final and dwell 0; start in RUN is ignored
      cfg_init = 6'd7; cfg_fin = 6'd7; cfg_dwell = 16'd0; cfg_th = 32'h7FFF_FFFE;
      add_vec(1, 1, 0, 32'h8000_0000, mk_obs(ST_ZERO, 7, 0, 1, 0, 0, 1, 0));
      add_vec(4, 0, 0, 32'h8000_0000, mk_obs(ST_RUN,  7, 1, 0, 0, 0, 1, 0));
      add_vec(3, 0, 0, 32'h8000_0000, mk_obs(ST_RUN,  7, 1, 0, 0, 0, 1, 0));
      add_vec(1, 0, 0, 32'h7FFF_FFFF, mk_obs(ST_RUN,  7, 1, 0, 0, 0, 1, 0));
      add_vec(2, 1, 0, 32'h7FFF_FFFF, mk_obs(ST_RUN,  7, 1, 0, 0, 0, 1, 0));
      add_vec(1, 0, 0, 32'h8000_0002, mk_obs(ST_LOCK, 7, 1, 0, 1, 0, 1, 0));
      add_vec(1, 0, 1, 32'h8000_0002, mk_obs(ST_IDLE, 7, 0, 0, 0, 0, 0, 0));

      foreach (vecs[k]) begin
         applyStimulus(vecs[k]);
         checkOutput($sformatf("vec%0d", k), vecs[k].exp);
      end
      i_start = 1'b0;
      i_abort = 1'b0;

      // Saturation retries: with dwell 3 the gain reaches 4 and locks on the 15th RUN cycle
      i_gain_sel_init = 6'd1; i_gain_sel_final = 6'd4; i_dwell = 16'd3;
      i_lock_th = 32'd100; i_err = 32'd10;
      i_start = 1'b1; tick(); i_start = 1'b0;
      run_cyc(4, 0, 0, 0);
      checkOutput("sat_run", mk_obs(ST_RUN, 1, 1, 0, 0, 0, 1, 0));
      run_cyc(15, 1, 0, 0);
      checkOutput("sat15_locked", mk_obs(ST_LOCK, 4, 1, 0, 1, 0, 1, 0));
      run_cyc(1, 1, 0, 0);
      checkOutput("sat_event1", mk_obs(ST_ZERO, 1, 0, 1, 0, 0, 1, 1));
      run_cyc(3, 0, 0, 0);
      checkOutput("retry_zero", mk_obs(ST_ZERO, 1, 0, 1, 0, 0, 1, 1));
      run_cyc(1, 0, 0, 0);
      checkOutput("retry_run", mk_obs(ST_RUN, 1, 1, 0, 0, 0, 1, 1));
      run_cyc(10, 0, 1, 0);
      run_cyc(1, 0, 0, 0);
      run_cyc(15, 0, 1, 0);
      checkOutput("sat_broken_run", mk_obs(ST_LOCK, 4, 1, 0, 1, 0, 1, 1));
      run_cyc(1, 0, 1, 0);
      checkOutput("sat_event2", mk_obs(ST_ZERO, 1, 0, 1, 0, 0, 1, 2));
      run_cyc(4, 0, 0, 0);
      run_cyc(16, 1, 0, 0);
      checkOutput("sat_event3", mk_obs(ST_ZERO, 1, 0, 1, 0, 0, 1, 3));
      run_cyc(4, 0, 0, 0);
      run_cyc(16, 1, 0, 0);
      checkOutput("fault_entry", mk_obs(ST_FAULT, 4, 0, 0, 0, 1, 0, 3));
      run_cyc(3, 0, 0, 0);
      checkOutput("fault_held", mk_obs(ST_FAULT, 4, 0, 0, 0, 1, 0, 3));
      i_start = 1'b1; tick(); i_start = 1'b0;
      checkOutput("fault_restart", mk_obs(ST_ZERO, 1, 0, 1, 0, 0, 1, 0));

      // Abort coinciding with the 16th saturated cycle wins and keeps the retry count
      run_cyc(4, 0, 0, 0);
      run_cyc(16, 1, 0, 0);
      checkOutput("restart_event", mk_obs(ST_ZERO, 1, 0, 1, 0, 0, 1, 1));
      run_cyc(4, 0, 0, 0);
      run_cyc(15, 1, 0, 0);
      run_cyc(1, 1, 0, 1);
      checkOutput("abort_vs_sat", mk_obs(ST_IDLE, 4, 0, 0, 0, 0, 0, 1));

      // Reset asserted mid-run clears outputs without waiting for a clock edge
      i_start = 1'b1; tick(); i_start = 1'b0;
      run_cyc(6, 0, 0, 0);
      checkOutput("pre_reset_run", mk_obs(ST_RUN, 1, 1, 0, 0, 0, 1, 0));
      #2;
      i_rst_n = 1'b0;
      #1;
      checkOutput("async_reset", mk_obs(ST_IDLE, 0, 0, 0, 0, 0, 0, 0));
      tick();
      i_rst_n = 1'b1;
      repeat (3) tick();
      checkOutput("after_async_reset", mk_obs(ST_IDLE, 0, 0, 0, 0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
